// File: rtl/bf8b_pkg.sv
// Shared definitions for the memory arbiter: access width codes, FSM states
// and the byte-lane helpers used by both the strobe and read-alignment paths.
package bf8b_pkg;

    localparam logic [1:0] MEM_ACC_8  = 2'b00;
    localparam logic [1:0] MEM_ACC_16 = 2'b01;
    localparam logic [1:0] MEM_ACC_32 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_t;

    // Unshifted byte-lane mask for an access width; the reserved code yields no lanes.
    function automatic logic [3:0] lane_mask(input logic [1:0] width);
        logic [3:0] mask;
        mask = 4'b0000;
        case (width)
            MEM_ACC_8:  mask = 4'b0001;
            MEM_ACC_16: mask = 4'b0011;
            MEM_ACC_32: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] ofs);
        logic mis;
        mis = 1'b1;
        case (width)
            MEM_ACC_8:  mis = 1'b0;
            MEM_ACC_16: mis = ofs[0];
            MEM_ACC_32: mis = (ofs != 2'b00);
            default:    mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Returns the winner as one-hot and as an index.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int j;

    // Scan from farthest to nearest so the nearest requester wins the final assignment.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin memory port arbiter with byte-lane formatting. One access takes
// IDLE -> ACCESS -> CAPTURE -> DONE, with ready pulsed during DONE.
module mem_arbiter
    import bf8b_pkg::*;
#(
    parameter int M_WIDTH    = 32,
    parameter int CLIENT_CNT = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CLIENT_CNT-1:0]              client_requests,
    input  logic [M_WIDTH*CLIENT_CNT-1:0]      client_addrs_packed,
    input  logic [CLIENT_CNT-1:0]              client_wes,
    input  logic [2*CLIENT_CNT-1:0]            client_data_widths_packed,
    input  logic [M_WIDTH*CLIENT_CNT-1:0]      client_data_outs_packed,
    output logic [CLIENT_CNT-1:0]              client_readies,
    output logic [CLIENT_CNT-1:0]              client_errs,
    output logic [M_WIDTH*CLIENT_CNT-1:0]      client_data_ins_packed,
    input  logic [M_WIDTH-1:0]                 mem_data_in,
    output logic [M_WIDTH-1:0]                 mem_data_out,
    output logic [M_WIDTH-$clog2(M_WIDTH/8)-1:0] mem_addr,
    output logic [M_WIDTH/8-1:0]               mem_we_outs
);

    localparam int LANES  = M_WIDTH / 8;
    localparam int OFS_W  = $clog2(LANES);
    localparam int ADDR_W = M_WIDTH - OFS_W;
    localparam int IDX_W  = (CLIENT_CNT > 1) ? $clog2(CLIENT_CNT) : 1;

    logic [M_WIDTH-1:0] addr_arr  [CLIENT_CNT];
    logic [M_WIDTH-1:0] wdata_arr [CLIENT_CNT];
    logic [1:0]         width_arr [CLIENT_CNT];
    logic [M_WIDTH-1:0] data_in_reg [CLIENT_CNT];

    generate
        for (genvar gi = 0; gi < CLIENT_CNT; gi++) begin : g_client
            assign addr_arr[gi]  = client_addrs_packed[gi*M_WIDTH +: M_WIDTH];
            assign wdata_arr[gi] = client_data_outs_packed[gi*M_WIDTH +: M_WIDTH];
            assign width_arr[gi] = client_data_widths_packed[gi*2 +: 2];
            assign client_data_ins_packed[gi*M_WIDTH +: M_WIDTH] = data_in_reg[gi];
        end
    endgenerate

    arb_state_t          state_reg;
    logic [IDX_W-1:0]    rr_ptr_reg;
    logic [IDX_W-1:0]    grant_reg;
    logic [OFS_W-1:0]    ofs_reg;
    logic [1:0]          width_reg;
    logic                we_reg;
    logic                mis_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [LANES-1:0]    mem_we_reg;
    logic [M_WIDTH-1:0]  mem_data_out_reg;
    logic [CLIENT_CNT-1:0] readies_reg;
    logic [CLIENT_CNT-1:0] errs_reg;

    logic [CLIENT_CNT-1:0] pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;

    rr_picker #(
        .N  (CLIENT_CNT),
        .IW (IDX_W)
    ) u_picker (
        .req   (client_requests),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Candidate access, formatted in IDLE so the port outputs are registered for ACCESS.
    logic [M_WIDTH-1:0] sel_addr;
    logic [1:0]         sel_width;
    logic               sel_we;
    logic               sel_mis;
    logic [OFS_W-1:0]   sel_ofs;
    logic [LANES-1:0]   sel_mask;
    logic [M_WIDTH-1:0] sel_wdata;

    assign sel_addr  = addr_arr[pick_idx];
    assign sel_width = width_arr[pick_idx];
    assign sel_we    = client_wes[pick_idx];
    assign sel_ofs   = sel_addr[OFS_W-1:0];
    assign sel_mis   = is_misaligned(sel_width, sel_addr[1:0]);
    assign sel_mask  = LANES'(lane_mask(sel_width)) << sel_ofs;
    assign sel_wdata = wdata_arr[pick_idx] << {sel_ofs, 3'b000};

    logic [LANES-1:0]   rd_lanes;
    logic [M_WIDTH-1:0] rd_mask;
    logic [M_WIDTH-1:0] rd_data;

    assign rd_lanes = LANES'(lane_mask(width_reg));
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_rd_mask
            assign rd_mask[gi*8 +: 8] = {8{rd_lanes[gi]}};
        end
    endgenerate
    assign rd_data = (mem_data_in >> {ofs_reg, 3'b000}) & rd_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            rr_ptr_reg       <= '0;
            grant_reg        <= '0;
            ofs_reg          <= '0;
            width_reg        <= MEM_ACC_8;
            we_reg           <= 1'b0;
            mis_reg          <= 1'b0;
            mem_addr_reg     <= '0;
            mem_we_reg       <= '0;
            mem_data_out_reg <= '0;
            readies_reg      <= '0;
            errs_reg         <= '0;
            for (int i = 0; i < CLIENT_CNT; i++) begin
                data_in_reg[i] <= '0;
            end
        end else begin
            readies_reg <= '0;
            errs_reg    <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_reg    <= pick_idx;
                        ofs_reg      <= sel_ofs;
                        width_reg    <= sel_width;
                        we_reg       <= sel_we;
                        mis_reg      <= sel_mis;
                        mem_addr_reg <= sel_addr[M_WIDTH-1:OFS_W];
                        if (sel_we && !sel_mis) begin
                            mem_we_reg       <= sel_mask;
                            mem_data_out_reg <= sel_wdata;
                        end else begin
                            mem_we_reg <= '0;
                        end
                        state_reg <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_we_reg <= '0;
                    state_reg  <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Memory word for the address presented in ACCESS is valid now.
                    if (!we_reg) begin
                        data_in_reg[grant_reg] <= mis_reg ? '0 : rd_data;
                    end
                    readies_reg[grant_reg] <= 1'b1;
                    errs_reg[grant_reg]    <= mis_reg;
                    state_reg              <= ST_DONE;
                end
                ST_DONE: begin
                    rr_ptr_reg <= (grant_reg == IDX_W'(CLIENT_CNT - 1)) ? '0 : grant_reg + IDX_W'(1);
                    state_reg  <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign client_readies = readies_reg;
    assign client_errs    = errs_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_we_outs    = mem_we_reg;
    assign mem_data_out   = mem_data_out_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, aligned/misaligned reads and writes,
// reset mid-transaction, two-client contention and lone-requester back-to-back.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [63:0] addrs;
    logic [1:0]  we;
    logic [3:0]  widths;
    logic [63:0] douts;
    logic [1:0]  readies;
    logic [1:0]  errs;
    logic [63:0] dins;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.M_WIDTH(32), .CLIENT_CNT(2)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .client_requests           (req),
        .client_addrs_packed       (addrs),
        .client_wes                (we),
        .client_data_widths_packed (widths),
        .client_data_outs_packed   (douts),
        .client_readies            (readies),
        .client_errs               (errs),
        .client_data_ins_packed    (dins),
        .mem_data_in               (mem_data_in),
        .mem_data_out              (mem_data_out),
        .mem_addr                  (mem_addr),
        .mem_we_outs               (mem_we)
    );

    task automatic set_client(input int c, input logic r, input logic [31:0] a,
                              input logic w, input logic [1:0] wd, input logic [31:0] d);
        req[c]             = r;
        addrs[c*32 +: 32]  = a;
        we[c]              = w;
        widths[c*2 +: 2]   = wd;
        douts[c*32 +: 32]  = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '0; addrs = '0; we = '0; widths = '0; douts = '0; mem_data_in = '0;
        repeat (2) @(negedge clk);
        checks++; if (readies !== 2'b00 || errs !== 2'b00) begin errors++;
            $display("FAIL reset_ready_err: got %b/%b expected 00/00", readies, errs); end
        checks++; if (mem_we !== 4'h0 || mem_addr !== 30'h0 || mem_data_out !== 32'h0) begin errors++;
            $display("FAIL reset_port: we=%h addr=%h dout=%h expected all 0", mem_we, mem_addr, mem_data_out); end
        checks++; if (dins !== 64'h0) begin errors++;
            $display("FAIL reset_data_ins: got %h expected 0", dins); end
        rst = 1'b1;
        @(negedge clk);
        $display("reset: readies=%b we=%h addr=%h", readies, mem_we, mem_addr);
    endtask

    task automatic test_single_read();
        mem_data_in = 32'hDEADBEEF;
        set_client(0, 1'b1, 32'h104, 1'b0, 2'b10, 32'h0);
        @(negedge clk);
        checks++; if (mem_addr !== 30'h41 || mem_we !== 4'h0) begin errors++;
            $display("FAIL rd32_access: addr=%h we=%h expected 41/0", mem_addr, mem_we); end
        checks++; if (readies !== 2'b00) begin errors++;
            $display("FAIL rd32_early_ready: got %b expected 00", readies); end
        @(negedge clk);
        checks++; if (readies !== 2'b00) begin errors++;
            $display("FAIL rd32_capture_ready: got %b expected 00", readies); end
        @(negedge clk);
        checks++; if (readies !== 2'b01 || errs !== 2'b00) begin errors++;
            $display("FAIL rd32_done: ready=%b err=%b expected 01/00", readies, errs); end
        checks++; if (dins[31:0] !== 32'hDEADBEEF) begin errors++;
            $display("FAIL rd32_data: got %h expected deadbeef", dins[31:0]); end
        $display("read c0 addr=104 w32 data=%h ready=%b err=%b", dins[31:0], readies, errs);
        req[0] = 1'b0;
        @(negedge clk);
        checks++; if (readies !== 2'b00) begin errors++;
            $display("FAIL rd32_ready_pulse: got %b expected 00", readies); end
    endtask

    task automatic test_byte_write();
        set_client(1, 1'b1, 32'h203, 1'b1, 2'b00, 32'h000000A5);
        @(negedge clk);
        checks++; if (mem_we !== 4'b1000 || mem_data_out !== 32'hA5000000 || mem_addr !== 30'h80) begin errors++;
            $display("FAIL wr8_access: we=%b dout=%h addr=%h expected 1000/a5000000/80", mem_we, mem_data_out, mem_addr); end
        @(negedge clk);
        checks++; if (mem_we !== 4'h0) begin errors++;
            $display("FAIL wr8_capture_we: got %b expected 0000", mem_we); end
        @(negedge clk);
        checks++; if (readies !== 2'b10 || errs !== 2'b00) begin errors++;
            $display("FAIL wr8_done: ready=%b err=%b expected 10/00", readies, errs); end
        checks++; if (dins[63:32] !== 32'h0) begin errors++;
            $display("FAIL wr8_no_readback: got %h expected 0", dins[63:32]); end
        $display("write c1 addr=203 w8 we=1000 dout=a5000000 ready=%b", readies);
        req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_narrow_reads();
        mem_data_in = 32'h1234ABCD;
        set_client(0, 1'b1, 32'h12, 1'b0, 2'b01, 32'h0);
        @(negedge clk);
        checks++; if (mem_addr !== 30'h4) begin errors++;
            $display("FAIL rd16_addr: got %h expected 4", mem_addr); end
        repeat (2) @(negedge clk);
        checks++; if (readies !== 2'b01 || dins[31:0] !== 32'h00001234) begin errors++;
            $display("FAIL rd16_data: ready=%b data=%h expected 01/00001234", readies, dins[31:0]); end
        $display("read c0 addr=12 w16 data=%h", dins[31:0]);
        req[0] = 1'b0;
        @(negedge clk);
        set_client(0, 1'b1, 32'h5, 1'b0, 2'b00, 32'h0);
        repeat (3) @(negedge clk);
        checks++; if (readies !== 2'b01 || dins[31:0] !== 32'h000000AB) begin errors++;
            $display("FAIL rd8_data: ready=%b data=%h expected 01/000000ab", readies, dins[31:0]); end
        $display("read c0 addr=5 w8 data=%h", dins[31:0]);
        req[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        set_client(0, 1'b1, 32'h101, 1'b1, 2'b10, 32'hFFFFFFFF);
        @(negedge clk);
        checks++; if (mem_we !== 4'h0) begin errors++;
            $display("FAIL mis_wr_access_we: got %b expected 0000", mem_we); end
        @(negedge clk);
        checks++; if (mem_we !== 4'h0 || readies !== 2'b00) begin errors++;
            $display("FAIL mis_wr_capture: we=%b ready=%b expected 0000/00", mem_we, readies); end
        @(negedge clk);
        checks++; if (readies !== 2'b01 || errs !== 2'b01 || mem_we !== 4'h0) begin errors++;
            $display("FAIL mis_wr_done: ready=%b err=%b we=%b expected 01/01/0000", readies, errs, mem_we); end
        $display("write c0 addr=101 w32 misaligned ready=%b err=%b", readies, errs);
        req[0] = 1'b0;
        @(negedge clk);
        checks++; if (errs !== 2'b00) begin errors++;
            $display("FAIL mis_err_pulse: got %b expected 00", errs); end
        set_client(0, 1'b1, 32'h3, 1'b0, 2'b01, 32'h0);
        repeat (3) @(negedge clk);
        checks++; if (readies !== 2'b01 || errs !== 2'b01 || dins[31:0] !== 32'h0) begin errors++;
            $display("FAIL mis_rd_done: ready=%b err=%b data=%h expected 01/01/0", readies, errs, dins[31:0]); end
        $display("read c0 addr=3 w16 misaligned data=%h err=%b", dins[31:0], errs);
        req[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        // Complete a client-0 access first so the pointer moves to client 1.
        set_client(0, 1'b1, 32'h0, 1'b0, 2'b10, 32'h0);
        repeat (3) @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        set_client(1, 1'b1, 32'h200, 1'b1, 2'b00, 32'h5A);
        @(negedge clk);
        checks++; if (mem_we !== 4'b0001) begin errors++;
            $display("FAIL rstmid_access_we: got %b expected 0001", mem_we); end
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_we !== 4'h0 || readies !== 2'b00) begin errors++;
            $display("FAIL rstmid_async: we=%b ready=%b expected 0000/00", mem_we, readies); end
        @(negedge clk);
        rst = 1'b1;
        req[1] = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (readies !== 2'b00) seen++;
        end
        checks++; if (seen != 0) begin errors++;
            $display("FAIL rstmid_no_ready: got %0d ready cycles expected 0", seen); end
        $display("reset mid-write c1: we cleared, ready cycles=%0d", seen);
    endtask

    task automatic test_contention();
        int n, last, exp_k;
        logic [1:0] exp_g;
        n = 0; last = 0;
        mem_data_in = 32'h0;
        set_client(0, 1'b1, 32'h0, 1'b0, 2'b10, 32'h0);
        set_client(1, 1'b1, 32'h100, 1'b0, 2'b10, 32'h0);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (readies !== 2'b00) begin
                exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
                exp_k = (n == 0) ? 3 : last + 4;
                checks++; if (readies !== exp_g) begin errors++;
                    $display("FAIL contention_grant%0d: got %b expected %b", n, readies, exp_g); end
                checks++; if (k != exp_k) begin errors++;
                    $display("FAIL contention_cycle%0d: got %0d expected %0d", n, k, exp_k); end
                $display("contention grant %0d: ready=%b at cycle %0d", n, readies, k);
                last = k;
                n++;
                if (n == 4) req = 2'b00;
            end
        end
        checks++; if (n != 4) begin errors++;
            $display("FAIL contention_count: got %0d expected 4", n); end
    endtask

    task automatic test_back_to_back();
        int n, last, exp_k;
        n = 0; last = 0;
        set_client(1, 1'b1, 32'h8, 1'b1, 2'b10, 32'h11223344);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (readies !== 2'b00) begin
                exp_k = (n == 0) ? 3 : last + 4;
                checks++; if (readies !== 2'b10 || k != exp_k) begin errors++;
                    $display("FAIL b2b_%0d: ready=%b cycle=%0d expected 10 at %0d", n, readies, k, exp_k); end
                $display("back-to-back c1 write %0d: ready=%b at cycle %0d", n, readies, k);
                last = k;
                n++;
                if (n == 2) req = 2'b00;
            end
        end
        checks++; if (n != 2) begin errors++;
            $display("FAIL b2b_count: got %0d expected 2", n); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_byte_write();
        test_narrow_reads();
        test_misaligned();
        test_reset_mid();
        test_contention();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
